alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Three-state (IDLE/EXEC/WB) sequencer that feeds an external combinational ALU
// from a small register file and retires results and status flags.
module alu_sequencer #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_inst,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  input  logic [31:0] alu_result,
  input  logic        alu_equal,
  input  logic        alu_above,
  input  logic        alu_below,
  input  logic        alu_overflow,
  input  logic        alu_error,
  output logic        done,
  output logic        illegal,
  output logic        flag_equal,
  output logic        flag_above,
  output logic        flag_below,
  output logic        flag_overflow,
  output logic        flag_error,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,  OP_LDI = 5'd1,  OP_ADD = 5'd3,  OP_SUB = 5'd4,
    OP_MUL = 5'd5,  OP_DIV = 5'd6,  OP_AND = 5'd7,  OP_OR  = 5'd8,
    OP_SHL = 5'd9,  OP_SHR = 5'd10, OP_CMP = 5'd11, OP_NOT = 5'd12
  } opcode_t;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [31:0] rf [1:NREGS-1];
  logic [31:0] res_q;
  logic        eq_q, above_q, below_q, ovf_q, err_q;

  logic [4:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic        is_nop, is_ldi, is_alu, is_cmp;
  logic [31:0] rs1_val, rs2_val, wr_data;
  logic        wr_en, in_exec, in_wb;

  assign opcode = ir[31:27];
  assign rd     = ir[26:24];
  assign rs1    = ir[23:21];
  assign rs2    = ir[20:18];
  assign imm    = ir[15:0];

  assign is_nop = (opcode == OP_NOP);
  assign is_ldi = (opcode == OP_LDI);
  assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_NOT);
  assign is_cmp = (opcode == OP_CMP);

  // r0 and any index beyond NREGS read as zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    rs1_val  = '0;
    rs2_val  = '0;
    dbg_data = '0;
    if (rs1 != 3'd0 && 32'(rs1) < NREGS)      rs1_val  = rf[rs1];
    if (rs2 != 3'd0 && 32'(rs2) < NREGS)      rs2_val  = rf[rs2];
    if (dbg_addr != 3'd0 && 32'(dbg_addr) < NREGS) dbg_data = rf[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    in_exec       = (state == EXEC) && !reset;
    in_wb         = (state == WB) && !reset;
    instr_ready   = (state == IDLE);
    done          = in_wb;
    illegal       = in_wb && !(is_nop || is_ldi || is_alu);
    alu_inst      = in_exec ? ir      : '0;
    alu_operand_a = in_exec ? rs1_val : '0;
    alu_operand_b = in_exec ? rs2_val : '0;
    wr_data       = is_ldi ? {16'h0000, imm} : res_q;
    wr_en         = in_wb && rd != 3'd0 && 32'(rd) < NREGS &&
                    (is_ldi || (is_alu && !is_cmp && !err_q));
    unique case (state)
      IDLE:    if (instr_valid) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= '0;
      res_q <= '0;
      {eq_q, above_q, below_q, ovf_q, err_q} <= '0;
      {flag_equal, flag_above, flag_below, flag_overflow, flag_error} <= '0;
      // NOTE: the register file is architectural state that reset must clear,
      // so it is built from resettable flops rather than an inferred RAM.
      rf <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == EXEC) begin
        res_q   <= alu_result;
        eq_q    <= alu_equal;
        above_q <= alu_above;
        below_q <= alu_below;
        ovf_q   <= alu_overflow;
        err_q   <= alu_error;
      end
      if (wr_en) rf[rd] <= wr_data;
      if (state == WB && is_alu) begin
        flag_overflow <= ovf_q;
        flag_error    <= err_q;
      end
      // Compare flags are sticky across non-CMP operations.
      if (state == WB && is_cmp) begin
        flag_equal <= eq_q;
        flag_above <= above_q;
        flag_below <= below_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU stub plus an
// instruction-level reference model of registers and flags.
module tb_alu_sequencer;

  typedef struct packed {
    logic [31:0] res;
    logic        eq, ab, be, ov, er;
  } alu_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_inst, alu_operand_a, alu_operand_b, alu_result;
  logic        alu_equal, alu_above, alu_below, alu_overflow, alu_error;
  logic        done, illegal;
  logic        flag_equal, flag_above, flag_below, flag_overflow, flag_error;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  alu_t        alu_out;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mregs [8];
  logic        m_eq, m_ab, m_be, m_ov, m_er;

  alu_sequencer #(.NREGS(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_inst(alu_inst),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_equal(alu_equal), .alu_above(alu_above),
    .alu_below(alu_below), .alu_overflow(alu_overflow), .alu_error(alu_error),
    .done(done), .illegal(illegal), .flag_equal(flag_equal),
    .flag_above(flag_above), .flag_below(flag_below),
    .flag_overflow(flag_overflow), .flag_error(flag_error),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Reference ALU; unsupported opcodes return poison so misuse shows up.
  function automatic alu_t alu_ref(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    alu_t r;
    logic [63:0] w;
    r = '0;
    r.eq = (a == b);
    r.ab = (a > b);
    r.be = (a < b);
    case (op)
      5'd3:  begin w = {32'h0, a} + {32'h0, b}; r.res = w[31:0]; r.ov = w[32]; end
      5'd4:  begin r.res = a - b; r.ov = (a < b); end
      5'd5:  begin w = {32'h0, a} * {32'h0, b}; r.res = w[31:0]; r.ov = |w[63:32]; end
      5'd6:  if (b == 32'h0) begin r.res = 32'hDEAD_BEEF; r.er = 1'b1; end
             else r.res = a / b;
      5'd7:  r.res = a & b;
      5'd8:  r.res = a | b;
      5'd9:  r.res = a << b[4:0];
      5'd10: r.res = a >> b[4:0];
      5'd11: r.res = a - b;
      5'd12: r.res = ~a;
      default: begin r.res = a ^ b ^ 32'h5A5A_5A5A; r.ov = 1'b1; r.er = 1'b1; end
    endcase
    return r;
  endfunction

  always_comb alu_out = alu_ref(alu_inst[31:27], alu_operand_a, alu_operand_b);
  assign alu_result   = alu_out.res;
  assign alu_equal    = alu_out.eq;
  assign alu_above    = alu_out.ab;
  assign alu_below    = alu_out.be;
  assign alu_overflow = alu_out.ov;
  assign alu_error    = alu_out.er;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, 2'b00, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    {m_eq, m_ab, m_be, m_ov, m_er} = '0;
  endtask

  // Instruction-level semantics of one retired instruction.
  task automatic model_exec(input logic [31:0] w);
    logic [4:0] op;
    logic [2:0] rd;
    alu_t       r;
    op = w[31:27];
    rd = w[26:24];
    if (op == 5'd1) begin
      if (rd != 3'd0) mregs[rd] = {16'h0000, w[15:0]};
    end else if (op >= 5'd3 && op <= 5'd12) begin
      r = alu_ref(op, mregs[w[23:21]], mregs[w[20:18]]);
      m_ov = r.ov;
      m_er = r.er;
      if (op == 5'd11) {m_eq, m_ab, m_be} = {r.eq, r.ab, r.be};
      else if (!r.er && rd != 3'd0) mregs[rd] = r.res;
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      total++;
      if (dbg_data !== mregs[i]) begin
        bad++;
        $display("FAIL reg_r%0d: got %h want %h", i, dbg_data, mregs[i]);
      end
    end
  endtask

  // Issue one instruction from IDLE and follow it through EXEC and WB.
  task automatic step(input logic [31:0] w, input bit keep, input logic [31:0] nxt);
    logic [2:0]  rd;
    logic [31:0] ea, eb, old_rd;
    logic [4:0]  op;
    logic        exp_ill;
    op      = w[31:27];
    rd      = w[26:24];
    ea      = mregs[w[23:21]];
    eb      = mregs[w[20:18]];
    old_rd  = mregs[rd];
    exp_ill = !(op <= 5'd1 || (op >= 5'd3 && op <= 5'd12));
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready: got %b want 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr = w;
    @(posedge clk); #1;
    if (keep) instr = nxt;
    else begin instr_valid = 1'b0; instr = $urandom; end
    #1;
    total++;
    if ({instr_ready, done, illegal} !== 3'b000) begin
      bad++;
      $display("FAIL exec_ctl: got %b want 000", {instr_ready, done, illegal});
    end
    total++;
    if (alu_inst !== w) begin
      bad++;
      $display("FAIL exec_inst: got %h want %h", alu_inst, w);
    end
    total++;
    if ({alu_operand_a, alu_operand_b} !== {ea, eb}) begin
      bad++;
      $display("FAIL exec_ops: got %h/%h want %h/%h", alu_operand_a, alu_operand_b, ea, eb);
    end
    @(posedge clk); #1;
    dbg_addr = rd;
    #1;
    total++;
    if ({done, illegal, instr_ready} !== {1'b1, exp_ill, 1'b0}) begin
      bad++;
      $display("FAIL wb_ctl: got %b want %b", {done, illegal, instr_ready}, {1'b1, exp_ill, 1'b0});
    end
    total++;
    if ({alu_inst, alu_operand_a, alu_operand_b} !== 96'h0) begin
      bad++;
      $display("FAIL wb_alu_idle: got %h %h %h want 0", alu_inst, alu_operand_a, alu_operand_b);
    end
    total++;
    if (dbg_data !== old_rd) begin
      bad++;
      $display("FAIL wb_prewrite: got %h want %h", dbg_data, old_rd);
    end
    model_exec(w);
    @(posedge clk); #1;
    dbg_addr = rd;
    #1;
    total++;
    if ({done, illegal, instr_ready} !== 3'b001) begin
      bad++;
      $display("FAIL retire_ctl: got %b want 001", {done, illegal, instr_ready});
    end
    total++;
    if (dbg_data !== mregs[rd]) begin
      bad++;
      $display("FAIL rd_value(op %0d r%0d): got %h want %h", op, rd, dbg_data, mregs[rd]);
    end
    total++;
    if ({flag_equal, flag_above, flag_below, flag_overflow, flag_error} !==
        {m_eq, m_ab, m_be, m_ov, m_er}) begin
      bad++;
      $display("FAIL flags(op %0d): got %b want %b", op,
               {flag_equal, flag_above, flag_below, flag_overflow, flag_error},
               {m_eq, m_ab, m_be, m_ov, m_er});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = $urandom;
    dbg_addr = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({done, illegal, alu_inst, alu_operand_a, alu_operand_b} !== 98'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %b%b %h want 0", done, illegal, alu_inst);
    end
    reset = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    #1;
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b want 1", instr_ready);
    end
    total++;
    if ({flag_equal, flag_above, flag_below, flag_overflow, flag_error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {flag_equal, flag_above, flag_below, flag_overflow, flag_error});
    end
    check_regs();
  endtask

  task automatic test_ldi_add();
    step(mk(5'd1, 3'd1, 3'd0, 3'd0, 16'd5), 1'b0, 32'h0);
    step(mk(5'd1, 3'd2, 3'd0, 3'd0, 16'd7), 1'b0, 32'h0);
    step(mk(5'd3, 3'd3, 3'd1, 3'd2, 16'd0), 1'b0, 32'h0);
    dbg_addr = 3'd3;
    #1;
    total++;
    if (dbg_data !== 32'd12 || flag_overflow !== 1'b0) begin
      bad++;
      $display("FAIL add_basic: got r3=%h ovf=%b want 0000000c ovf=0", dbg_data, flag_overflow);
    end
  endtask

  task automatic test_overflow();
    step(mk(5'd1, 3'd4, 3'd0, 3'd0, 16'd16), 1'b0, 32'h0);
    step(mk(5'd1, 3'd1, 3'd0, 3'd0, 16'hFFFF), 1'b0, 32'h0);
    step(mk(5'd9, 3'd1, 3'd1, 3'd4, 16'd0), 1'b0, 32'h0);
    step(mk(5'd3, 3'd1, 3'd1, 3'd1, 16'd0), 1'b0, 32'h0);
    dbg_addr = 3'd1;
    #1;
    total++;
    if (dbg_data !== 32'hFFFE_0000 || flag_overflow !== 1'b1) begin
      bad++;
      $display("FAIL add_overflow: got r1=%h ovf=%b want fffe0000 ovf=1", dbg_data, flag_overflow);
    end
  endtask

  task automatic test_div_zero();
    step(mk(5'd1, 3'd1, 3'd0, 3'd0, 16'd10), 1'b0, 32'h0);
    step(mk(5'd1, 3'd3, 3'd0, 3'd0, 16'h0055), 1'b0, 32'h0);
    step(mk(5'd6, 3'd3, 3'd1, 3'd0, 16'd0), 1'b0, 32'h0);
    dbg_addr = 3'd3;
    #1;
    total++;
    if (dbg_data !== 32'h55 || flag_error !== 1'b1) begin
      bad++;
      $display("FAIL div_zero: got r3=%h err=%b want 00000055 err=1", dbg_data, flag_error);
    end
  endtask

  task automatic test_cmp();
    step(mk(5'd1, 3'd1, 3'd0, 3'd0, 16'd3), 1'b0, 32'h0);
    step(mk(5'd1, 3'd2, 3'd0, 3'd0, 16'd9), 1'b0, 32'h0);
    step(mk(5'd1, 3'd5, 3'd0, 3'd0, 16'h0077), 1'b0, 32'h0);
    step(mk(5'd11, 3'd5, 3'd1, 3'd2, 16'd0), 1'b0, 32'h0);
    dbg_addr = 3'd5;
    #1;
    total++;
    if ({flag_equal, flag_above, flag_below} !== 3'b001 || dbg_data !== 32'h77) begin
      bad++;
      $display("FAIL cmp_below: got eab=%b r5=%h want 001 r5=00000077",
               {flag_equal, flag_above, flag_below}, dbg_data);
    end
    check_regs();
  endtask

  task automatic test_illegal();
    step(mk(5'd20, 3'd4, 3'd1, 3'd2, 16'hABCD), 1'b0, 32'h0);
    step(mk(5'd2, 3'd6, 3'd1, 3'd2, 16'h1111), 1'b0, 32'h0);
    check_regs();
    step(mk(5'd1, 3'd0, 3'd0, 3'd0, 16'h1234), 1'b0, 32'h0);
    dbg_addr = 3'd0;
    #1;
    total++;
    if (dbg_data !== 32'h0) begin
      bad++;
      $display("FAIL r0_write: got %h want 00000000", dbg_data);
    end
  endtask

  // Valid held high: each instruction is accepted on the first IDLE cycle and
  // depends on the result of the one before it.
  task automatic test_back_to_back();
    logic [31:0] prog [4];
    prog[0] = mk(5'd1, 3'd5, 3'd0, 3'd0, 16'd3);
    prog[1] = mk(5'd3, 3'd6, 3'd5, 3'd5, 16'd0);
    prog[2] = mk(5'd5, 3'd7, 3'd6, 3'd6, 16'd0);
    prog[3] = mk(5'd4, 3'd5, 3'd7, 3'd6, 16'd0);
    for (int k = 0; k < 4; k++)
      step(prog[k], k < 3, (k < 3) ? prog[k + 1] : 32'h0);
    dbg_addr = 3'd7;
    #1;
    total++;
    if (dbg_data !== 32'd36) begin
      bad++;
      $display("FAIL b2b_chain: got r7=%h want 00000024", dbg_data);
    end
    check_regs();
  endtask

  task automatic test_random();
    logic [31:0] prog [80];
    bit          keep [80];
    logic [31:0] rnd;
    logic [4:0]  op;
    int unsigned sel;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 15);
      rnd = $urandom;
      if (sel >= 13) op = (sel == 15) ? 5'($urandom_range(13, 31)) : 5'd1;
      else           op = 5'(sel);
      prog[n] = {op, rnd[26:0]};
      keep[n] = (n != 79) && ($urandom_range(0, 1) == 1);
    end
    for (int n = 0; n < 80; n++)
      step(prog[n], keep[n], (n < 79) ? prog[n + 1] : 32'h0);
    check_regs();
  endtask

  task automatic test_reset_mid_exec();
    step(mk(5'd1, 3'd1, 3'd0, 3'd0, 16'd4), 1'b0, 32'h0);
    step(mk(5'd1, 3'd2, 3'd0, 3'd0, 16'd6), 1'b0, 32'h0);
    instr_valid = 1'b1;
    instr = mk(5'd3, 3'd3, 3'd1, 3'd2, 16'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({done, alu_inst} !== 33'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got done=%b inst=%h want 0", done, alu_inst);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if ({instr_ready, done} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset_ctl: got %b want 10", {instr_ready, done});
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      dbg_addr = 3'd3;
      #1;
      total++;
      if ({done, dbg_data} !== 33'h0) begin
        bad++;
        $display("FAIL abandoned_instr: got done=%b r3=%h want 0", done, dbg_data);
      end
    end
    check_regs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ldi_add();
    test_overflow();
    test_div_zero();
    test_cmp();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
